regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port general-purpose register file with an integrated write-pending scoreboard.
//   - Serves N decode-stage read ports and M writeback-stage write ports.
//   - Register 0 is hardwired to zero.
//   - Optional write-to-read bypass.
//   - One busy bit per register, so decode can stall on an operand whose producer has not yet written back.
// PARAMETERS
//   DATA_W  32  register width
//   ADDR_W  5   register address width; 2**ADDR_W registers
//   NUM_RD  2   read ports, >=1
//   NUM_WR  1   write ports, >=1
//   BYPASS  1   1: same-cycle write data forwarded to readers; 0: readers see the stored value
// PORTS
//   clk      in   1               clock, rising edge
//   rst      in   1               asynchronous, active-low reset (0 = reset asserted)
//   we       in   NUM_WR          per write port enable
//   waddr    in   NUM_WR*ADDR_W   write addresses, port k at [k*ADDR_W +: ADDR_W]
//   wdata    in   NUM_WR*DATA_W   write data, port k at [k*DATA_W +: DATA_W]
//   re       in   NUM_RD          per read port enable
//   raddr    in   NUM_RD*ADDR_W   read addresses, packed as for waddr
//   rdata    out  NUM_RD*DATA_W   read data (combinational)
//   rbusy    out  NUM_RD          1: operand pending, decode must stall (combinational)
//   sb_set   in   1               issue: mark sb_addr busy
//   sb_addr  in   ADDR_W          destination register of the issuing instruction
//   sb_flush in   1               squash: clear all busy bits
// BEHAVIOUR
//   Reset
//   - rst low clears every register and every busy bit asynchronously.
//   - While rst is low, all rdata are 0 and all rbusy are 0.
//   Write
//   - On posedge clk, regs[waddr[k]] <= wdata[k] when we[k]=1 and waddr[k]!=0.
//   - Several ports writing the same address: the highest-index port wins.
//   - Writes to address 0 are discarded.
//   Read, per port i, evaluated in priority order:
//   - raddr=0 -> rdata 0, rbusy 0.
//   - re=0 -> rdata 0, rbusy 0.
//   - BYPASS=1 and some enabled write port matches raddr -> rdata = wdata of the highest-index matching port; rbusy 0.
//   - Otherwise -> rdata = regs[raddr]; rbusy = busy[raddr].
//   - With BYPASS=0, a same-cycle write is not visible: the old value is returned and rbusy still reflects busy[raddr].
//   - Each read port is independent; no port interacts with another.
//   Scoreboard (posedge clk), applied in priority order:
//   - sb_flush=1 -> all busy bits <= 0. A same-cycle sb_set is ignored (the issuing instruction is squashed).
//   - Else, for each address a != 0:
//     - busy[a] <= 1 if sb_set and sb_addr==a, else
//     - busy[a] <= 0 if any we[k] with waddr[k]==a, else
//     - busy[a] holds.
//   - Set beats clear: a new producer is issued to the same register as the retiring one.
//   - busy[0] is constant 0.
//   Timing
//   - A write retired in cycle t is readable from the array in cycle t+1, or in cycle t through the bypass.
//   - A busy bit set in cycle t is visible on rbusy from cycle t+1.
//   Reset mid-operation
//   - Asserting rst discards any in-flight write and all busy state immediately.
//   - No pending state survives deassertion.
// STRUCTURE
//   Shared define.v
//   - Keeps RegBus, RegAddrBus, RegNum, RegNumLog2, ZeroWord, WriteEnable, ReadEnable.
//   - Adds RstActiveLow = 1'b0 and SbBusy = 1'b1.
//   - Read and write enables stay active-high.
//   Sub-module
//   - regfile_sb holds the 2**ADDR_W busy vector with its set/clear/flush logic.
//   - Array, write-priority mux and per-port read/bypass mux stay in regfile_mp, built from generate loops over NUM_RD and NUM_WR.
// TESTING (NUM_RD=2, NUM_WR=2, BYPASS=1 unless noted)
//   1. Reset: pulse rst low mid-cycle after writing r5=0x1234.
//      -> rdata, rbusy = 0 immediately; r5 reads 0 after rst returns high.
//   2. Write collision: we=2'b11, waddr={r7,r7}, wdata={0xBBBB,0xAAAA}.
//      -> same-cycle read of r7 gives 0xBBBB; next cycle also 0xBBBB.
//   3. Write to r0: we[0]=1, waddr=0, wdata=0xFFFF_FFFF.
//      -> r0 reads 0 forever; busy never set, even when sb_set with sb_addr=0.
//   4. Scoreboard: sb_set r3 in cycle t.
//      -> rbusy=1 for r3 from t+1; writeback of r3=0x55 in cycle t+3 gives rdata=0x55 and rbusy=0 in t+3.
//      -> In t+4, rbusy=0 from the array.
//   5. Collisions:
//      - sb_set r4 in the same cycle as a write of r4 -> r4 busy in the next cycle.
//      - sb_flush together with sb_set r9 -> no register busy.
//   6. BYPASS=0: write r2=0x77 while reading r2 in the same cycle.
//      -> rdata is the old value that cycle, 0x77 the next cycle.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file and its busy scoreboard.
// Enables are active-high; reset is active-low.
package regfile_mp_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int RegNum     = 32;
   localparam int RegNumLog2 = 5;

   localparam logic [RegBus-1:0] ZeroWord = '0;

   localparam logic WriteEnable  = 1'b1;
   localparam logic ReadEnable   = 1'b1;
   localparam logic RstActiveLow = 1'b0;
   localparam logic SbBusy       = 1'b1;

   function automatic logic is_zero_addr(input logic [RegAddrBus-1:0] a);
      return a == '0;
   endfunction

endpackage

// File: rtl/regfile_sb.sv
// Per-register busy vector: set on issue, clear on writeback, flush on squash.
// Set beats clear so a re-issued producer keeps the register pending.
module regfile_sb
   import regfile_mp_pkg::*;
#(
   parameter int ADDR_W = RegAddrBus,
   parameter int NUM_WR = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   input  logic                     sb_flush,
   output logic [2**ADDR_W-1:0]     busy
);

   localparam int NREG = 2**ADDR_W;

   logic [NREG-1:0] clr;
   logic [NREG-1:0] nxt;

   always_comb begin
      clr = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         if (we[k] == WriteEnable)
            clr[waddr[k*ADDR_W +: ADDR_W]] = 1'b1;
      end
      nxt = busy & ~clr;
      if (sb_set)
         nxt[sb_addr] = SbBusy;
      nxt[0] = 1'b0;
      if (sb_flush)
         nxt = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstActiveLow)
         busy <= '0;
      else
         busy <= nxt;
   end

endmodule

// File: rtl/regfile_mp.sv
// N-read / M-write register file, r0 hardwired to zero, optional
// write-to-read bypass and a busy scoreboard for decode stalls.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = RegBus,
   parameter int ADDR_W = RegAddrBus,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 1,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic [NUM_WR*DATA_W-1:0] wdata,
   input  logic [NUM_RD-1:0]        re,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic [NUM_RD-1:0]        rbusy,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   input  logic                     sb_flush
);

   localparam int NREG = 2**ADDR_W;

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   busy;
   logic [ADDR_W-1:0] wa [NUM_WR];
   logic [DATA_W-1:0] wd [NUM_WR];

   regfile_sb #(
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .sb_set   (sb_set),
      .sb_addr  (sb_addr),
      .sb_flush (sb_flush),
      .busy     (busy)
   );

   for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
      assign wa[k] = waddr[k*ADDR_W +: ADDR_W];
      assign wd[k] = wdata[k*DATA_W +: DATA_W];
   end

   // Ascending port order: the highest-index writer lands last and wins.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstActiveLow) begin
         for (int r = 0; r < NREG; r++)
            regs[r] <= '0;
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (we[k] == WriteEnable && wa[k] != '0)
               regs[wa[k]] <= wd[k];
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] fwd;
      logic [DATA_W-1:0] rd;
      logic              hit;
      logic              rb;

      assign ra = raddr[i*ADDR_W +: ADDR_W];

      always_comb begin
         hit = 1'b0;
         fwd = '0;
         for (int k = 0; k < NUM_WR; k++) begin
            if (we[k] == WriteEnable && wa[k] == ra) begin
               hit = 1'b1;
               fwd = wd[k];
            end
         end
      end

      always_comb begin
         rd = '0;
         rb = 1'b0;
         if (rst != RstActiveLow && re[i] == ReadEnable && ra != '0) begin
            if (BYPASS != 0 && hit) begin
               rd = fwd;
            end else begin
               rd = regs[ra];
               rb = busy[ra];
            end
         end
      end

      assign rdata[i*DATA_W +: DATA_W] = rd;
      assign rbusy[i] = rb;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two DUTs (bypass on/off) share stimulus; a
// behavioural model queues expectations that a monitor checks.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  we = '0;
   logic [9:0]  waddr = '0;
   logic [63:0] wdata = '0;
   logic [1:0]  re = '0;
   logic [9:0]  raddr = '0;
   logic        sb_set = 1'b0;
   logic [4:0]  sb_addr = '0;
   logic        sb_flush = 1'b0;
   logic [63:0] rdata_b, rdata_n;
   logic [1:0]  rbusy_b, rbusy_n;

   int total = 0;
   int bad = 0;
   bit done = 0;

   typedef struct {
      logic [63:0] rd_b;
      logic [63:0] rd_n;
      logic [1:0]  rb_b;
      logic [1:0]  rb_n;
   } ent_t;

   ent_t q[$];

   logic [31:0] m_regs [32];
   bit          m_busy [32];

   always #5 clk = ~clk;

   regfile_mp #(
      .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)
   ) u_byp (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
      .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush)
   );

   regfile_mp #(
      .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)
   ) u_nob (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
      .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush)
   );

   // Architectural effect of one clock edge, from the current inputs.
   function automatic void model_edge();
      int a;
      if (!rst) begin
         for (int r = 0; r < 32; r++) begin
            m_regs[r] = 0;
            m_busy[r] = 0;
         end
         return;
      end
      for (int k = 0; k < 2; k++) begin
         a = int'(waddr[k*5 +: 5]);
         if (we[k]) begin
            if (a != 0) m_regs[a] = wdata[k*32 +: 32];
            m_busy[a] = 0;
         end
      end
      if (sb_flush) begin
         for (int r = 0; r < 32; r++) m_busy[r] = 0;
      end else if (sb_set && sb_addr != 0) begin
         m_busy[sb_addr] = 1;
      end
   endfunction

   function automatic void read_port(input int i, input bit byp,
                                     output logic [31:0] d,
                                     output logic b);
      int a;
      bit hit;
      logic [31:0] f;
      a = int'(raddr[i*5 +: 5]);
      d = 0;
      b = 0;
      hit = 0;
      f = 0;
      if (!rst || a == 0 || !re[i]) return;
      for (int k = 0; k < 2; k++) begin
         if (we[k] && int'(waddr[k*5 +: 5]) == a) begin
            hit = 1;
            f = wdata[k*32 +: 32];
         end
      end
      if (byp && hit) begin
         d = f;
      end else begin
         d = m_regs[a];
         b = m_busy[a];
      end
   endfunction

   function automatic ent_t predict();
      ent_t e;
      logic [31:0] d;
      logic b;
      for (int i = 0; i < 2; i++) begin
         read_port(i, 1, d, b);
         e.rd_b[i*32 +: 32] = d;
         e.rb_b[i] = b;
         read_port(i, 0, d, b);
         e.rd_n[i*32 +: 32] = d;
         e.rb_n[i] = b;
      end
      return e;
   endfunction

   task automatic step(input bit r, input logic [1:0] w,
                       input logic [4:0] wa1, input logic [4:0] wa0,
                       input logic [31:0] wd1, input logic [31:0] wd0,
                       input logic [4:0] ra1, input logic [4:0] ra0,
                       input bit ss, input logic [4:0] sa,
                       input bit sf);
      @(posedge clk);
      model_edge();
      #1;
      rst = r;
      we = w;
      waddr = {wa1, wa0};
      wdata = {wd1, wd0};
      re = 2'b11;
      raddr = {ra1, ra0};
      sb_set = ss;
      sb_addr = sa;
      sb_flush = sf;
      q.push_back(predict());
   endtask

   function automatic logic [4:0] ra_rand();
      if ($urandom_range(0, 3) == 0) return 5'($urandom);
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin : monitor
      ent_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (rdata_b !== e.rd_b) begin
               bad++;
               $display("FAIL rdata_byp got=%h exp=%h", rdata_b, e.rd_b);
            end
            total++;
            if (rbusy_b !== e.rb_b) begin
               bad++;
               $display("FAIL rbusy_byp got=%b exp=%b", rbusy_b, e.rb_b);
            end
            total++;
            if (rdata_n !== e.rd_n) begin
               bad++;
               $display("FAIL rdata_nob got=%h exp=%h", rdata_n, e.rd_n);
            end
            total++;
            if (rbusy_n !== e.rb_n) begin
               bad++;
               $display("FAIL rbusy_nob got=%b exp=%b", rbusy_n, e.rb_n);
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin : driver
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = 0;
         m_busy[r] = 0;
      end
      // reset state
      step(0, 2'b00, 0, 0, 0, 0, 5, 3, 0, 0, 0);
      step(1, 2'b00, 0, 0, 0, 0, 5, 3, 0, 0, 0);
      // write r5, then reset pulse mid-cycle with a write in flight
      step(1, 2'b01, 0, 5, 0, 32'h1234, 5, 5, 1, 5, 0);
      step(1, 2'b00, 0, 0, 0, 0, 5, 5, 0, 0, 0);
      step(0, 2'b01, 0, 6, 0, 32'h9, 5, 6, 0, 0, 0);
      step(1, 2'b00, 0, 0, 0, 0, 5, 6, 0, 0, 0);
      // write collision on r7
      step(1, 2'b11, 7, 7, 32'hBBBB, 32'hAAAA, 7, 7, 0, 0, 0);
      step(1, 2'b00, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      // write to r0, sb_set r0
      step(1, 2'b01, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 0);
      step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // scoreboard r3
      step(1, 2'b00, 0, 0, 0, 0, 3, 3, 1, 3, 0);
      step(1, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0, 0);
      step(1, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0, 0);
      step(1, 2'b01, 0, 3, 0, 32'h55, 3, 3, 0, 0, 0);
      step(1, 2'b00, 0, 0, 0, 0, 3, 3, 0, 0, 0);
      // set beats clear on r4; flush beats set on r9
      step(1, 2'b01, 0, 4, 0, 32'h44, 4, 4, 1, 4, 0);
      step(1, 2'b00, 0, 0, 0, 0, 4, 9, 1, 9, 1);
      step(1, 2'b00, 0, 0, 0, 0, 4, 9, 0, 0, 0);
      // old value vs bypass on r2
      step(1, 2'b01, 0, 2, 0, 32'h11, 2, 0, 0, 0, 0);
      step(1, 2'b01, 0, 2, 0, 32'h77, 2, 2, 0, 0, 0);
      step(1, 2'b00, 0, 0, 0, 0, 2, 2, 0, 0, 0);
      // random traffic
      for (int n = 0; n < 1500; n++) begin
         step($urandom_range(0, 99) != 0, 2'($urandom),
              ra_rand(), ra_rand(), $urandom, $urandom,
              ra_rand(), ra_rand(),
              $urandom_range(0, 2) == 0, ra_rand(),
              $urandom_range(0, 29) == 0);
         re = 2'($urandom);
         q[$] = predict();
      end
      repeat (3) @(posedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d exp=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
